// File: rtl/frame_column_loader_if.sv
// Valid/ready word stream carrying frame packets into the column loader.
interface frame_column_loader_if #(
    parameter int W = 32
);
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_column_loader.sv
// Unpacks header + NumRows data words into the column's FrameData slices and
// fires a single one-hot FrameStrobe line to commit the frame into the tiles.
//
// state  | meaning
// HEADER | waiting for a header word; bad sync words are dropped
// LOAD   | collecting data words into row slices 0..NumRows-1
// STROBE | FrameStrobe[index] high for StrobeCycles cycles
// HOLD   | one-cycle latch hold margin; frame_done if a strobe was issued
module frame_column_loader #(
    parameter int          FrameBitsPerRow = 32,
    parameter int          MaxFramesPerCol = 20,
    parameter int          NumRows         = 4,
    parameter int          StrobeCycles    = 1,
    parameter logic [15:0] SyncWord        = 16'hFAB1
) (
    input  logic                               UserCLK,
    input  logic                               Reset,
    frame_column_loader_if.slave               s_stream,
    input  logic                               err_clr,
    output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               err_sync,
    output logic                               err_index
);
    localparam int CntW = (NumRows > 1) ? $clog2(NumRows) : 1;

    typedef enum logic [1:0] {HEADER, LOAD, STROBE, HOLD} state_t;

    state_t                             state_q;
    logic [7:0]                         index_q;
    logic [CntW-1:0]                    word_cnt_q;
    logic [3:0]                         strobe_cnt_q;
    logic [NumRows*FrameBitsPerRow-1:0] frame_data_q;
    logic [MaxFramesPerCol-1:0]         frame_strobe_q;
    logic                               frame_done_q;
    logic                               err_sync_q;
    logic                               err_index_q;
    logic                               ready;
    logic                               xfer;

    // Ready depends on state only so the upstream source can never loop through us.
    assign ready           = (state_q == HEADER) || (state_q == LOAD);
    assign s_stream.s_ready = ready;
    assign xfer            = s_stream.s_valid && ready;

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state_q        <= HEADER;
            index_q        <= '0;
            word_cnt_q     <= '0;
            strobe_cnt_q   <= '0;
            frame_data_q   <= '0;
            frame_strobe_q <= '0;
            frame_done_q   <= 1'b0;
            err_sync_q     <= 1'b0;
            err_index_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // Clear first so a coincident error event below takes priority.
            if (err_clr) begin
                err_sync_q  <= 1'b0;
                err_index_q <= 1'b0;
            end
            case (state_q)
                HEADER: begin
                    if (xfer) begin
                        if (s_stream.s_data[31:16] == SyncWord) begin
                            index_q    <= s_stream.s_data[7:0];
                            word_cnt_q <= '0;
                            state_q    <= LOAD;
                        end else begin
                            err_sync_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        for (int r = 0; r < NumRows; r++) begin
                            if (word_cnt_q == CntW'(r)) begin
                                frame_data_q[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_stream.s_data;
                            end
                        end
                        if (word_cnt_q == CntW'(NumRows - 1)) begin
                            word_cnt_q <= '0;
                            if (int'(index_q) < MaxFramesPerCol) begin
                                for (int i = 0; i < MaxFramesPerCol; i++) begin
                                    frame_strobe_q[i] <= (int'(index_q) == i);
                                end
                                strobe_cnt_q <= 4'(StrobeCycles - 1);
                                state_q      <= STROBE;
                            end else begin
                                err_index_q <= 1'b1;
                                state_q     <= HOLD;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                        end
                    end
                end
                STROBE: begin
                    if (strobe_cnt_q == 4'd0) begin
                        frame_strobe_q <= '0;
                        frame_done_q   <= 1'b1;
                        state_q        <= HOLD;
                    end else begin
                        strobe_cnt_q <= strobe_cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    state_q <= HEADER;
                end
                default: begin
                    state_q <= HEADER;
                end
            endcase
        end
    end

    assign FrameData   = frame_data_q;
    assign FrameStrobe = frame_strobe_q;
    assign busy        = (state_q != HEADER);
    assign frame_done  = frame_done_q;
    assign err_sync    = err_sync_q;
    assign err_index   = err_index_q;
endmodule

// File: tb/tb_frame_column_loader.sv
// Bench for frame_column_loader: two instances (1-cycle and 3-cycle strobe)
// driven with directed and random packets, checked by a scoreboard monitor.
module tb_frame_column_loader;
    localparam int NR = 4;
    localparam int W  = 32;
    localparam int NF = 20;

    typedef struct {
        logic [7:0]      idx;
        logic [NR*W-1:0] data;
        int              edge_n;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    logic [W-1:0]    sd    [2];
    logic            sv    [2];
    logic            clr   [2];
    logic            rst_t [2];
    logic            rdy   [2];
    logic            bsy   [2];
    logic            fdone [2];
    logic            es    [2];
    logic            ei    [2];
    logic [NR*W-1:0] fd    [2];
    logic [NF-1:0]   fs    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        frame_column_loader_if #(.W(W)) sif ();
        assign sif.s_data  = sd[g];
        assign sif.s_valid = sv[g];
        assign rdy[g]      = sif.s_ready;

        frame_column_loader #(
            .FrameBitsPerRow(W),
            .MaxFramesPerCol(NF),
            .NumRows        (NR),
            .StrobeCycles   ((g == 0) ? 1 : 3),
            .SyncWord       (16'hFAB1)
        ) u_dut (
            .UserCLK    (clk),
            .Reset      (rst_t[g]),
            .s_stream   (sif),
            .err_clr    (clr[g]),
            .FrameData  (fd[g]),
            .FrameStrobe(fs[g]),
            .busy       (bsy[g]),
            .frame_done (fdone[g]),
            .err_sync   (es[g]),
            .err_index  (ei[g])
        );
    end

    int n_chk  = 0;
    int n_fail = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference state: row contents and sticky flags as the stream rules dictate.
    logic [W-1:0] m_rows [2][NR];
    logic         m_es   [2];
    logic         m_ei   [2];

    function automatic void chk(input int d, input string name,
                                input logic [NR*W-1:0] act, input logic [NR*W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h (edge %0d)", d, name, act, exp, ecnt);
        end
    endfunction

    function automatic logic [NR*W-1:0] m_frame(input int d);
        logic [NR*W-1:0] v;
        for (int r = 0; r < NR; r++) v[r*W +: W] = m_rows[d][r];
        return v;
    endfunction

    function automatic void model_reset(input int d);
        for (int r = 0; r < NR; r++) m_rows[d][r] = '0;
        m_es[d] = 1'b0;
        m_ei[d] = 1'b0;
    endfunction

    function automatic void push_exp(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_pop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Monitor: samples 2 time units after each rising edge, away from the driver.
    task automatic monitor(input int g);
        bit   in_s;
        bit   hold_now;
        int   len;
        int   sc;
        exp_t cur;
        in_s = 1'b0;
        len  = 0;
        sc   = (g == 0) ? 1 : 3;
        cur.idx = '0; cur.data = '0; cur.edge_n = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst_t[g]) begin
                chk(g, "rst_strobe", fs[g], '0);
                chk(g, "rst_framedata", fd[g], '0);
                chk(g, "rst_ready", rdy[g], 1);
                chk(g, "rst_done", fdone[g], 0);
                chk(g, "rst_err_sync", es[g], 0);
                chk(g, "rst_err_index", ei[g], 0);
                in_s = 1'b0;
                len  = 0;
            end else begin
                hold_now = in_s && (fs[g] == '0);
                if (fdone[g] || hold_now) chk(g, "frame_done", fdone[g], hold_now);
                if (fs[g] != '0) begin
                    chk(g, "ready_in_strobe", rdy[g], 0);
                    if (!in_s) begin
                        if (q_size(g) == 0) begin
                            chk(g, "unexpected_strobe", fs[g], '0);
                        end else begin
                            cur = q_pop(g);
                            chk(g, "strobe_onehot", fs[g], NF'(1) << cur.idx);
                            chk(g, "strobe_data", fd[g], cur.data);
                            chk(g, "strobe_edge", ecnt, cur.edge_n);
                            in_s = 1'b1;
                            len  = 1;
                        end
                    end else begin
                        len++;
                        chk(g, "strobe_held", fs[g], NF'(1) << cur.idx);
                        chk(g, "strobe_fd_stable", fd[g], cur.data);
                    end
                end else if (in_s) begin
                    chk(g, "strobe_len", len, sc);
                    chk(g, "ready_in_hold", rdy[g], 0);
                    in_s = 1'b0;
                end
            end
        end
    endtask

    // Presents one word; returns at the falling edge after it was accepted.
    task automatic send_word(input int d, input logic [W-1:0] w, input bit gap,
                             input bit push, input exp_t e);
        int   n;
        exp_t ee;
        n = 0;
        if (gap) begin
            sv[d] = 1'b0;
            @(negedge clk);
        end
        sv[d] = 1'b1;
        sd[d] = w;
        while (rdy[d] !== 1'b1) begin
            if (n == 40) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut%0d ready_timeout: ready low for %0d cycles, expected high", d, n);
                sv[d] = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
        if (push) begin
            ee        = e;
            ee.edge_n = ecnt + 1;
            push_exp(d, ee);
        end
        @(negedge clk);
        sv[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (!(rdy[d] === 1'b1 && bsy[d] === 1'b0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(d, "idle_reached", (n < 40), 1);
    endtask

    // gap: 0 = continuous valid, 1 = idle cycle before every data word, 2 = random
    task automatic send_packet(input int d, input logic [7:0] idx,
                               input logic [NR*W-1:0] payload, input int gap);
        exp_t e;
        bit   gp;
        e.idx    = idx;
        e.data   = payload;
        e.edge_n = 0;
        send_word(d, {16'hFAB1, 8'($urandom), idx}, 1'b0, 1'b0, e);
        for (int k = 0; k < NR; k++) begin
            gp = (gap == 1) || (gap == 2 && $urandom_range(0, 1) == 1);
            send_word(d, payload[k*W +: W], gp, (k == NR - 1) && (int'(idx) < NF), e);
        end
        for (int k = 0; k < NR; k++) m_rows[d][k] = payload[k*W +: W];
        if (int'(idx) >= NF) m_ei[d] = 1'b1;
        chk(d, "fd_after_load", fd[d], m_frame(d));
        chk(d, "err_sync", es[d], m_es[d]);
        chk(d, "err_index", ei[d], m_ei[d]);
        if (int'(idx) >= NF) begin
            chk(d, "ready_err_hold", rdy[d], 0);
            chk(d, "busy_err_hold", bsy[d], 1);
            @(negedge clk);
            chk(d, "ready_after_err_hold", rdy[d], 1);
            chk(d, "busy_after_err_hold", bsy[d], 0);
        end
    endtask

    task automatic bad_header(input int d);
        logic [15:0] bad;
        exp_t        e;
        e.idx = '0; e.data = '0; e.edge_n = 0;
        do bad = 16'($urandom); while (bad == 16'hFAB1);
        send_word(d, {bad, 16'($urandom)}, 1'b0, 1'b0, e);
        m_es[d] = 1'b1;
        chk(d, "err_sync_bad_hdr", es[d], m_es[d]);
    endtask

    task automatic clr_pulse(input int d);
        clr[d] = 1'b1;
        @(negedge clk);
        clr[d] = 1'b0;
        m_es[d] = 1'b0;
        m_ei[d] = 1'b0;
        chk(d, "err_sync_cleared", es[d], m_es[d]);
        chk(d, "err_index_cleared", ei[d], m_ei[d]);
    endtask

    function automatic logic [NR*W-1:0] rand_payload();
        logic [NR*W-1:0] p;
        for (int k = 0; k < NR; k++) p[k*W +: W] = $urandom;
        return p;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   d;
        int   r;
        e.idx = '0; e.data = '0; e.edge_n = 0;
        for (int i = 0; i < 2; i++) begin
            sd[i] = '0; sv[i] = 1'b0; clr[i] = 1'b0; rst_t[i] = 1'b1;
            model_reset(i);
        end
        fork
            monitor(0);
            monitor(1);
        join_none
        repeat (3) @(negedge clk);
        rst_t[0] = 1'b0;
        rst_t[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk(i, "idle_ready", rdy[i], 1);
            chk(i, "idle_busy", bsy[i], 0);
        end

        // Basic frame, continuous valid
        send_packet(0, 8'd3, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 0);

        // Bad sync header is dropped, following packet still lands
        wait_idle(0);
        send_word(0, 32'h1234_0002, 1'b0, 1'b0, e);
        m_es[0] = 1'b1;
        chk(0, "err_sync_set", es[0], 1);
        send_packet(0, 8'd2, rand_payload(), 0);
        clr_pulse(0);

        // Out-of-range index: no strobe, data still updated
        send_packet(0, 8'd21, rand_payload(), 0);
        send_packet(0, 8'd20, rand_payload(), 0);
        send_packet(0, 8'd0, rand_payload(), 0);

        // Valid toggling every cycle during LOAD
        send_packet(0, 8'd5, rand_payload(), 1);

        // Sync-like data word inside LOAD is plain data
        send_packet(0, 8'd12, {32'h0BADF00D, 32'h1234_5678, 32'hFAB1_0005, 32'hCAFE0001}, 0);

        // err_clr coinciding with a new sync error: set wins, index flag clears
        wait_idle(0);
        chk(0, "err_index_before_clr", ei[0], m_ei[0]);
        clr[0] = 1'b1;
        send_word(0, 32'h0000_0001, 1'b0, 1'b0, e);
        clr[0] = 1'b0;
        m_es[0] = 1'b1;
        m_ei[0] = 1'b0;
        chk(0, "set_wins_sync", es[0], m_es[0]);
        chk(0, "clr_index", ei[0], m_ei[0]);

        // Reset while the second data word is presented
        wait_idle(0);
        send_word(0, 32'hFAB1_0006, 1'b0, 1'b0, e);
        send_word(0, 32'hAAAA_0000, 1'b0, 1'b0, e);
        sv[0] = 1'b1; sd[0] = 32'hBBBB_0001; rst_t[0] = 1'b1;
        @(negedge clk);
        sv[0] = 1'b0; rst_t[0] = 1'b0;
        model_reset(0);
        send_packet(0, 8'd7, rand_payload(), 0);

        // Three-cycle strobe instance
        send_packet(1, 8'd19, rand_payload(), 0);
        send_packet(1, 8'd1, rand_payload(), 1);

        // Reset in the middle of a three-cycle strobe
        send_packet(1, 8'd9, rand_payload(), 0);
        chk(1, "strobe_active_before_rst", fs[1], NF'(1) << 9);
        rst_t[1] = 1'b1;
        @(negedge clk);
        rst_t[1] = 1'b0;
        model_reset(1);
        send_packet(1, 8'd4, rand_payload(), 0);

        // Random traffic on both instances
        for (int it = 0; it < 40; it++) begin
            d = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r == 0)      bad_header(d);
            else if (r == 1) clr_pulse(d);
            else             send_packet(d, 8'($urandom_range(0, 23)), rand_payload(), $urandom_range(0, 2));
        end

        repeat (12) @(negedge clk);
        chk(0, "scoreboard_drained", q0.size(), 0);
        chk(1, "scoreboard_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
